parity_tx: RTL and testbench

PARITY_TX -- requirements
Module: parity_tx

---
 rtl/parity_tx_if.sv | 28 ++
 rtl/parity_tx.sv | 116 +++++++++++
 tb/tb_parity_tx.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/parity_tx_if.sv
// Handshake and serial-line bundle for parity_tx.
// master: the producer offering nibbles; slave: the transmitter itself.
interface parity_tx_if;
  logic [3:0] din;
  logic       valid;
  logic       ready;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (
    output din,
    output valid,
    input  ready,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  din,
    input  valid,
    output ready,
    output tx,
    output busy,
    output done
  );
endinterface

// File: rtl/parity_tx.sv
// Serial nibble transmitter: start bit, four data bits LSB first, parity bit, stop bit.
// Defining PARITY_TX_PAR_EN adds the parallel tap outputs a, b, c, d and p.
module parity_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned ODD          = 0
) (
  input  logic       clk,
  input  logic       rst,
  parity_tx_if.slave bus
`ifdef PARITY_TX_PAR_EN
  ,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       p
`endif
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  localparam logic [7:0] CntMax = 8'(CLKS_PER_BIT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] data_q, data_d;
  logic       par_q, par_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       bit_end;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    par_d   = par_q;
    bit_end = (cnt_q == CntMax);

    if (state_q == StIdle) begin
      if (bus.valid && !busy_q) begin
        state_d = StStart;
        cnt_d   = '0;
        idx_d   = '0;
        data_d  = bus.din;
        par_d   = (^bus.din) ^ ODD[0];
      end
    end else if (!bit_end) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = '0;
      unique case (state_q)
        StStart:  state_d = StData;
        StData: begin
          if (idx_q == 2'd3) begin
            state_d = StParity;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
        StParity: state_d = StStop;
        StStop:   state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end

    // Outputs are registered from next-state values so tx leads the state by no cycle.
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = data_d[idx_d];
      StParity: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_d == StStop) && (cnt_d == CntMax);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready = ~busy_q;
  assign bus.tx    = tx_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

`ifdef PARITY_TX_PAR_EN
  assign a = data_q[3];
  assign b = data_q[2];
  assign c = data_q[1];
  assign d = data_q[0];
  assign p = par_q;
`endif

endmodule

// File: tb/tb_parity_tx.sv
// Directed bench for parity_tx: one even-parity instance at 4 clocks/bit and one
// odd-parity instance at 1 clock/bit, sharing clock and reset.
module tb_parity_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  parity_tx_if if0 ();
  parity_tx_if if1 ();

`ifdef PARITY_TX_PAR_EN
  logic a0, b0, c0, d0, p0;
  logic a1, b1, c1, d1, p1;
`endif

  parity_tx #(.CLKS_PER_BIT(4), .ODD(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
`ifdef PARITY_TX_PAR_EN
    ,
    .a   (a0),
    .b   (b0),
    .c   (c0),
    .d   (d0),
    .p   (p0)
`endif
  );

  parity_tx #(.CLKS_PER_BIT(1), .ODD(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
`ifdef PARITY_TX_PAR_EN
    ,
    .a   (a1),
    .b   (b1),
    .c   (c1),
    .d   (d1),
    .p   (p1)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic v, input logic [3:0] nib);
    if (sel == 0) begin
      if0.valid = v;
      if0.din   = nib;
    end else begin
      if1.valid = v;
      if1.din   = nib;
    end
  endtask

  function automatic logic tx_of(input int sel);
    return (sel == 0) ? if0.tx : if1.tx;
  endfunction
  function automatic logic ready_of(input int sel);
    return (sel == 0) ? if0.ready : if1.ready;
  endfunction
  function automatic logic busy_of(input int sel);
    return (sel == 0) ? if0.busy : if1.busy;
  endfunction
  function automatic logic done_of(input int sel);
    return (sel == 0) ? if0.done : if1.done;
  endfunction

  // Transfers nib, then checks every cycle of the frame against the expected bit
  // sequence. With hold set, valid stays high with din=3 throughout the frame.
  task automatic send_frame(input int sel, input int cpb, input logic odd,
                            input logic [3:0] nib, input logic exp_par, input logic hold);
    logic [6:0] bits;
    logic       obs_p;
    bits  = {1'b1, exp_par, nib[3], nib[2], nib[1], nib[0], 1'b0};
    obs_p = 1'bx;
    drive(sel, 1'b1, nib);
    tick();
    if (hold) drive(sel, 1'b1, 4'h3);
    else      drive(sel, 1'b0, nib);
    check($sformatf("ready_low%0d", sel), 8'(ready_of(sel)), 8'd0);
`ifdef PARITY_TX_PAR_EN
    if (sel == 0) check("par_tap", {3'd0, a0, b0, c0, d0, p0},
                        {3'd0, nib[3], nib[2], nib[1], nib[0], exp_par});
`endif
    for (int b = 0; b < 7; b++) begin
      for (int c = 0; c < cpb; c++) begin
        check($sformatf("tx%0d_n%0h_b%0d_c%0d", sel, nib, b, c), 8'(tx_of(sel)), 8'(bits[b]));
        check($sformatf("done%0d_n%0h_b%0d_c%0d", sel, nib, b, c), 8'(done_of(sel)),
              8'((b == 6) && (c == cpb - 1)));
        check($sformatf("busy%0d_b%0d", sel, b), 8'(busy_of(sel)), 8'd1);
        if (b == 5 && c == 0) obs_p = tx_of(sel);
        tick();
      end
    end
    check($sformatf("ready_back%0d", sel), 8'(ready_of(sel)), 8'd1);
    check($sformatf("busy_end%0d", sel), 8'(busy_of(sel)), 8'd0);
    check($sformatf("tx_idle%0d", sel), 8'(tx_of(sel)), 8'd1);
    check($sformatf("par_sum%0d_n%0h", sel, nib), 8'($countones({nib, obs_p}) & 1), 8'(odd));
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b1, 4'hF);
    drive(1, 1'b1, 4'hF);

    // Reset held two cycles with valid high: nothing may start.
    tick();
    tick();
    check("rst_tx", 8'(if0.tx), 8'd1);
    check("rst_ready", 8'(if0.ready), 8'd1);
    check("rst_busy", 8'(if0.busy), 8'd0);
    check("rst_done", 8'(if0.done), 8'd0);
    check("rst_tx1", 8'(if1.tx), 8'd1);
    check("rst_busy1", 8'(if1.busy), 8'd0);
    rst = 1'b0;
    drive(0, 1'b0, 4'h0);
    drive(1, 1'b0, 4'h0);
    tick();
    check("post_rst_busy", 8'(if0.busy), 8'd0);
    check("post_rst_tx", 8'(if0.tx), 8'd1);

    // Even frame 1011: 0,1,1,0,1,1,1
    send_frame(0, 4, 1'b0, 4'b1011, 1'b1, 1'b0);

    // Busy ignore: C sent while 3 offered, then 3 accepted once ready returns
    send_frame(0, 4, 1'b0, 4'hC, 1'b0, 1'b1);
    send_frame(0, 4, 1'b0, 4'h3, 1'b0, 1'b0);

    // Abort during DATA of A
    drive(0, 1'b1, 4'hA);
    tick();
    drive(0, 1'b0, 4'hA);
    for (int i = 0; i < 5; i++) tick();
    check("abort_in_data", 8'(if0.tx), 8'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_tx", 8'(if0.tx), 8'd1);
    check("abort_busy", 8'(if0.busy), 8'd0);
    check("abort_ready", 8'(if0.ready), 8'd1);
    tick();
    check("abort_stay_idle", 8'(if0.tx), 8'd1);
    send_frame(0, 4, 1'b0, 4'h5, 1'b0, 1'b0);

    // Odd parity at one clock per bit
    send_frame(1, 1, 1'b1, 4'b0000, 1'b1, 1'b0);
    send_frame(1, 1, 1'b1, 4'b0111, 1'b0, 1'b0);

    // All nibbles back to back, odd parity
    for (int n = 0; n < 16; n++) begin
      logic [3:0] nib;
      nib = 4'(n);
      send_frame(1, 1, 1'b1, nib, ~(^nib), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
